glitch_capture_pipe: RTL

Parametrised successor to the single-stage result register on the glitched clock domain. Delays the DUT result (sum) through a configurable pipeline of DEPTH stages and, while armed, compares each delivered sample against a golden value carried alongside. Counts samples and faults, and latches the first faulty sample for readout by the glitch campaign controller. Sits between the glitched datapath under attack and the result/UART readout logic.

---
 rtl/glitch_capture_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/glitch_capture_pipe.sv
// Glitch capture pipeline: delays the attacked datapath result through DEPTH
// register stages, compares each delivered sample against its golden value
// while a capture window is armed, counts samples/faults and latches the
// first faulty sample for the campaign controller.
module glitch_capture_pipe #(
  parameter int WIDTH         = 5,
  parameter int DEPTH         = 1,
  parameter int CNT_W         = 16,
  parameter int STOP_ON_FAULT = 0
) (
  input  logic             glitched_clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] golden,
  input  logic             arm,
  input  logic             clr,
  input  logic [CNT_W-1:0] window,
  output logic             out_valid,
  output logic [WIDTH-1:0] finout,
  output logic             fault_pulse,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [WIDTH-1:0] first_data,
  output logic [WIDTH-1:0] first_golden,
  output logic [CNT_W-1:0] first_idx,
  output logic             first_vld,
  output logic             armed,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_q;
  state_t state_d;

  logic             pipe_vld  [DEPTH];
  logic [WIDTH-1:0] pipe_sum  [DEPTH];
  logic [WIDTH-1:0] pipe_gold [DEPTH];

  logic [WIDTH-1:0] gold_last;
  logic             mismatch;
  logic             clear;
  logic             count;
  logic [CNT_W-1:0] sample_inc;
  logic [CNT_W-1:0] fault_inc;

  assign out_valid = pipe_vld[DEPTH-1];
  assign finout    = pipe_sum[DEPTH-1];
  assign gold_last = pipe_gold[DEPTH-1];
  assign mismatch  = out_valid && (finout != gold_last);

  assign sample_inc = (sample_cnt == CNT_MAX) ? sample_cnt : sample_cnt + CNT_W'(1);
  assign fault_inc  = (fault_cnt  == CNT_MAX) ? fault_cnt  : fault_cnt  + CNT_W'(1);

  assign armed = (state_q == ARMED);
  assign done  = (state_q == DONE);

  // Free-running delay line of {valid, sum, golden}; never stalls.
  always_ff @(posedge glitched_clk) begin
    // NOTE: the stage arrays are reset explicitly so that a reset mid-window
    // discards every in-flight sample instead of replaying stale data.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_sum[i]  <= '0;
        pipe_gold[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= in_valid;
      pipe_sum[0]  <= sum;
      pipe_gold[0] <= golden;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_sum[i]  <= pipe_sum[i-1];
        pipe_gold[i] <= pipe_gold[i-1];
      end
    end
  end

  // Capture-window FSM state register.
  always_ff @(posedge glitched_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic plus the clear/count strobes for the counter bank.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    clear   = 1'b0;
    count   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          clear   = 1'b1;
        end
      end
      ARMED: begin
        if (out_valid) begin
          count = 1'b1;
          if (((window != '0) && (sample_inc == window)) ||
              ((STOP_ON_FAULT != 0) && mismatch)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (arm) begin
          state_d = ARMED;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // clr dominates arm and any compare event in the same cycle.
    if (clr) begin
      state_d = IDLE;
      clear   = 1'b1;
      count   = 1'b0;
    end
  end

  // Counters, fault pulse and first-fault capture, updated one cycle after
  // the compared sample leaves the pipeline.
  always_ff @(posedge glitched_clk) begin
    if (!rst || clear) begin
      fault_pulse  <= 1'b0;
      fault_cnt    <= '0;
      sample_cnt   <= '0;
      first_data   <= '0;
      first_golden <= '0;
      first_idx    <= '0;
      first_vld    <= 1'b0;
    end else begin
      fault_pulse <= 1'b0;
      if (count) begin
        sample_cnt <= sample_inc;
        if (mismatch) begin
          fault_cnt   <= fault_inc;
          fault_pulse <= 1'b1;
          if (!first_vld) begin
            first_data   <= finout;
            first_golden <= gold_last;
            first_idx    <= sample_cnt;
            first_vld    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
